// File: rtl/bp_initiator.sv
// bp_initiator: single-outstanding register-access initiator over BytePipe.
// Optional response timeout compiled in with `define BP_INITIATOR_TIMEOUT_EN.
module bp_initiator #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_cg,
   input  logic       i_req_valid,
   output logic       o_req_ready,
   input  logic       i_req_wr,
   input  logic [6:0] i_req_addr,
   input  logic [7:0] i_req_data,
   input  logic [7:0] i_req_expect,
   output logic [7:0] o_bp_data,
   output logic       o_bp_valid,
   input  logic       i_bp_ready,
   input  logic [7:0] i_bp_data,
   input  logic       i_bp_valid,
   output logic       o_bp_ready,
   output logic       o_rsp_valid,
   input  logic       i_rsp_ready,
   output logic [7:0] o_rsp_data,
   output logic       o_rsp_mismatch,
   output logic       o_rsp_timeout
);
   typedef enum logic [2:0] {IDLE, CMD, DATA, RESP, DONE} state_t;
   state_t     state;
   logic       wr_q;
   logic [7:0] data_q;
   logic [7:0] exp_q;
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
      $error("bp_initiator: TIMEOUT_CYCLES must be 1..255");
   end
`ifdef BP_INITIATOR_TIMEOUT_EN
   localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);
   logic [7:0] cnt;
   logic [7:0] cnt_nxt;
   assign cnt_nxt = cnt + 8'd1;
`else
   assign o_rsp_timeout = 1'b0;
`endif
   // Ready/valid outputs mirror the state, so the state case alone decides transfers.
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state          <= IDLE;
         wr_q           <= 1'b0;
         data_q         <= 8'h00;
         exp_q          <= 8'h00;
         o_req_ready    <= 1'b1;
         o_bp_valid     <= 1'b0;
         o_bp_data      <= 8'h00;
         o_bp_ready     <= 1'b0;
         o_rsp_valid    <= 1'b0;
         o_rsp_data     <= 8'h00;
         o_rsp_mismatch <= 1'b0;
`ifdef BP_INITIATOR_TIMEOUT_EN
         o_rsp_timeout  <= 1'b0;
         cnt            <= 8'h00;
`endif
      end else if (i_cg) begin
         case (state)
            IDLE:
               if (i_req_valid) begin
                  wr_q        <= i_req_wr;
                  data_q      <= i_req_data;
                  exp_q       <= i_req_expect;
                  o_req_ready <= 1'b0;
                  o_bp_valid  <= 1'b1;
                  o_bp_data   <= {i_req_wr, i_req_addr};
                  state       <= CMD;
               end
            CMD:
               if (i_bp_ready) begin
                  o_bp_data  <= wr_q ? data_q : o_bp_data;
                  o_bp_valid <= wr_q;
                  o_bp_ready <= !wr_q;
                  state      <= wr_q ? DATA : RESP;
`ifdef BP_INITIATOR_TIMEOUT_EN
                  cnt        <= 8'h00;
`endif
               end
            DATA:
               if (i_bp_ready) begin
                  o_bp_valid <= 1'b0;
                  o_bp_ready <= 1'b1;
                  state      <= RESP;
`ifdef BP_INITIATOR_TIMEOUT_EN
                  cnt        <= 8'h00;
`endif
               end
            RESP:
               if (i_bp_valid) begin
                  o_rsp_data     <= i_bp_data;
                  o_rsp_mismatch <= i_bp_data != exp_q;
                  o_bp_ready     <= 1'b0;
                  o_rsp_valid    <= 1'b1;
                  state          <= DONE;
`ifdef BP_INITIATOR_TIMEOUT_EN
                  o_rsp_timeout  <= 1'b0;
               end else if (cnt_nxt == TO_LIM) begin
                  o_rsp_data     <= 8'h00;
                  o_rsp_mismatch <= 1'b0;
                  o_rsp_timeout  <= 1'b1;
                  o_bp_ready     <= 1'b0;
                  o_rsp_valid    <= 1'b1;
                  cnt            <= cnt_nxt;
                  state          <= DONE;
               end else begin
                  cnt <= cnt_nxt;
`endif
               end
            DONE:
               if (i_rsp_ready) begin
                  o_rsp_valid <= 1'b0;
                  o_req_ready <= 1'b1;
                  state       <= IDLE;
               end
            default: begin
               o_req_ready <= 1'b1;
               o_bp_valid  <= 1'b0;
               o_bp_ready  <= 1'b0;
               o_rsp_valid <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
endmodule

// File: tb/tb_bp_initiator.sv
// tb_bp_initiator: directed self-checking bench for bp_initiator (TIMEOUT_CYCLES=4).
module tb_bp_initiator;
   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_cg = 1'b1;
   logic       i_req_valid = 1'b0;
   logic       i_req_wr = 1'b0;
   logic [6:0] i_req_addr = 7'h00;
   logic [7:0] i_req_data = 8'h00;
   logic [7:0] i_req_expect = 8'h00;
   logic       i_bp_ready = 1'b0;
   logic [7:0] i_bp_data = 8'h00;
   logic       i_bp_valid = 1'b0;
   logic       i_rsp_ready = 1'b0;
   logic       o_req_ready;
   logic [7:0] o_bp_data;
   logic       o_bp_valid;
   logic       o_bp_ready;
   logic       o_rsp_valid;
   logic [7:0] o_rsp_data;
   logic       o_rsp_mismatch;
   logic       o_rsp_timeout;
   int         checks = 0;
   int         errors = 0;
   int         rsp_cnt = 0;
   logic [7:0] sent[$];

   bp_initiator #(.TIMEOUT_CYCLES(4)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cg(i_cg),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wr(i_req_wr),
      .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_req_expect(i_req_expect),
      .o_bp_data(o_bp_data), .o_bp_valid(o_bp_valid), .i_bp_ready(i_bp_ready),
      .i_bp_data(i_bp_data), .i_bp_valid(i_bp_valid), .o_bp_ready(o_bp_ready),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
      .o_rsp_mismatch(o_rsp_mismatch), .o_rsp_timeout(o_rsp_timeout)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) begin
      if (o_bp_valid && i_bp_ready && i_cg) sent.push_back(o_bp_data);
      if (o_rsp_valid && i_rsp_ready && i_cg) rsp_cnt++;
   end

   task automatic step;
      @(posedge i_clk);
      #1;
   endtask

   // Drives one unstalled transaction and reports what the DUT returned.
   task automatic run_txn(input logic wr, input logic [6:0] a, input logic [7:0] d, input logic [7:0] e,
                          input logic rv, input logic [7:0] rb,
                          output int lat, output logic [7:0] rd, output logic mm, output logic to);
      i_req_valid = 1'b1; i_req_wr = wr; i_req_addr = a; i_req_data = d; i_req_expect = e;
      i_bp_ready = 1'b1; i_bp_valid = rv; i_bp_data = rb; i_rsp_ready = 1'b0;
      step();
      i_req_valid = 1'b0;
      lat = 1;
      while (!o_rsp_valid && lat < 40) begin
         step();
         lat++;
      end
      if (!o_rsp_valid) lat = -1;
      rd = o_rsp_data; mm = o_rsp_mismatch; to = o_rsp_timeout;
      i_rsp_ready = 1'b1;
      step();
      i_rsp_ready = 1'b0; i_bp_valid = 1'b0;
   endtask

   task automatic test_reset;
      @(posedge i_clk);
      #1;
      checks++;
      if ({o_bp_valid, o_bp_data, o_bp_ready, o_rsp_valid, o_rsp_data, o_rsp_mismatch, o_rsp_timeout} !== 20'h0) begin
         errors++;
         $display("FAIL reset_outputs got bpv=%b bpd=%h bpr=%b rv=%b rd=%h mm=%b to=%b want all 0",
                  o_bp_valid, o_bp_data, o_bp_ready, o_rsp_valid, o_rsp_data, o_rsp_mismatch, o_rsp_timeout);
      end
      step();
      i_rst_n = 1'b1;
      step();
      checks++;
      if ({o_req_ready, o_bp_valid, o_bp_ready, o_rsp_valid} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_release got rq=%b bpv=%b bpr=%b rv=%b want 1000", o_req_ready, o_bp_valid, o_bp_ready, o_rsp_valid);
      end
   endtask

   task automatic test_read;
      sent.delete();
      i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_addr = 7'h05; i_req_data = 8'hFF; i_req_expect = 8'h00;
      i_bp_ready = 1'b1; i_bp_valid = 1'b1; i_bp_data = 8'h3C; i_rsp_ready = 1'b0;
      step();
      i_req_valid = 1'b0;
      checks++;
      if ({o_req_ready, o_bp_valid, o_bp_data} !== {1'b0, 1'b1, 8'h05}) begin
         errors++;
         $display("FAIL read_cmd got rq=%b bpv=%b bpd=%h want 0 1 05", o_req_ready, o_bp_valid, o_bp_data);
      end
      step();
      checks++;
      if ({o_bp_valid, o_bp_ready, o_rsp_valid} !== 3'b010) begin
         errors++;
         $display("FAIL read_resp got bpv=%b bpr=%b rv=%b want 010", o_bp_valid, o_bp_ready, o_rsp_valid);
      end
      step();
      checks++;
      if ({o_rsp_valid, o_rsp_data, o_rsp_mismatch, o_rsp_timeout, o_bp_ready} !== {1'b1, 8'h3C, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL read_done got rv=%b rd=%h mm=%b to=%b bpr=%b want 1 3c 1 0 0",
                  o_rsp_valid, o_rsp_data, o_rsp_mismatch, o_rsp_timeout, o_bp_ready);
      end
      i_bp_valid = 1'b0; i_rsp_ready = 1'b1;
      step();
      i_rsp_ready = 1'b0;
      checks++;
      if ({o_rsp_valid, o_req_ready} !== 2'b01) begin
         errors++;
         $display("FAIL read_idle got rv=%b rq=%b want 0 1", o_rsp_valid, o_req_ready);
      end
      checks++;
      if (sent.size() != 1 || sent[0] !== 8'h05) begin
         errors++;
         $display("FAIL read_bytes got n=%0d first=%h want n=1 first=05", sent.size(), sent.size() > 0 ? sent[0] : 8'h00);
      end
   endtask

   task automatic test_write;
      sent.delete();
      i_req_valid = 1'b1; i_req_wr = 1'b1; i_req_addr = 7'h12; i_req_data = 8'hA5; i_req_expect = 8'h00;
      i_bp_ready = 1'b1; i_bp_valid = 1'b1; i_bp_data = 8'h00; i_rsp_ready = 1'b0;
      step();
      i_req_valid = 1'b0;
      checks++;
      if ({o_bp_valid, o_bp_data} !== {1'b1, 8'h92}) begin
         errors++;
         $display("FAIL write_cmd got bpv=%b bpd=%h want 1 92", o_bp_valid, o_bp_data);
      end
      step();
      checks++;
      if ({o_bp_valid, o_bp_data, o_bp_ready} !== {1'b1, 8'hA5, 1'b0}) begin
         errors++;
         $display("FAIL write_data got bpv=%b bpd=%h bpr=%b want 1 a5 0", o_bp_valid, o_bp_data, o_bp_ready);
      end
      step();
      checks++;
      if ({o_bp_valid, o_bp_ready, o_rsp_valid} !== 3'b010) begin
         errors++;
         $display("FAIL write_resp got bpv=%b bpr=%b rv=%b want 010", o_bp_valid, o_bp_ready, o_rsp_valid);
      end
      step();
      checks++;
      if ({o_rsp_valid, o_rsp_data, o_rsp_mismatch} !== {1'b1, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL write_done got rv=%b rd=%h mm=%b want 1 00 0", o_rsp_valid, o_rsp_data, o_rsp_mismatch);
      end
      i_bp_valid = 1'b0; i_rsp_ready = 1'b1;
      step();
      i_rsp_ready = 1'b0;
      checks++;
      if (sent.size() != 2 || sent[0] !== 8'h92 || sent[1] !== 8'hA5) begin
         errors++;
         $display("FAIL write_bytes got n=%0d want n=2 bytes 92 a5", sent.size());
      end
   endtask

   task automatic test_stall;
      int rc0;
      logic bad;
      sent.delete();
      rc0 = rsp_cnt;
      bad = 1'b0;
      i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_addr = 7'h33; i_req_expect = 8'h7E;
      i_bp_ready = 1'b0; i_bp_valid = 1'b1; i_bp_data = 8'h7E; i_rsp_ready = 1'b0;
      step();
      i_req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         if ({o_bp_valid, o_bp_data, o_bp_ready, o_rsp_valid} !== {1'b1, 8'h33, 1'b0, 1'b0}) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL stall_cmd_hold got bpv=%b bpd=%h want 1 33 held 5 cycles", o_bp_valid, o_bp_data);
      end
      i_bp_ready = 1'b1;
      step();
      step();
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if ({o_rsp_valid, o_rsp_data, o_rsp_mismatch} !== {1'b1, 8'h7E, 1'b0}) bad = 1'b1;
         step();
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL stall_done_hold got rv=%b rd=%h mm=%b want 1 7e 0 held", o_rsp_valid, o_rsp_data, o_rsp_mismatch);
      end
      i_bp_valid = 1'b0; i_rsp_ready = 1'b1;
      step();
      i_rsp_ready = 1'b0;
      step();
      checks++;
      if (rsp_cnt - rc0 != 1 || sent.size() != 1 || sent[0] !== 8'h33) begin
         errors++;
         $display("FAIL stall_single got rsp=%0d bytes=%0d want rsp=1 bytes=1 (33)", rsp_cnt - rc0, sent.size());
      end
   endtask

   task automatic test_cg;
      logic bad;
      sent.delete();
      bad = 1'b0;
      i_cg = 1'b0;
      i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_addr = 7'h40; i_req_expect = 8'h00;
      i_bp_ready = 1'b1; i_bp_valid = 1'b0; i_rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if ({o_req_ready, o_bp_valid} !== 2'b10) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL cg_idle_hold got rq=%b bpv=%b want 1 0", o_req_ready, o_bp_valid);
      end
      i_cg = 1'b1;
      step();
      i_req_valid = 1'b0; i_cg = 1'b0;
      step();
      step();
      checks++;
      if ({o_bp_valid, o_bp_data, o_bp_ready} !== {1'b1, 8'h40, 1'b0} || sent.size() != 0) begin
         errors++;
         $display("FAIL cg_cmd_hold got bpv=%b bpd=%h bpr=%b bytes=%0d want 1 40 0 0", o_bp_valid, o_bp_data, o_bp_ready, sent.size());
      end
      i_cg = 1'b1;
      step();
      i_bp_valid = 1'b1; i_bp_data = 8'h00;
      step();
      checks++;
      if ({o_rsp_valid, o_rsp_data, o_rsp_mismatch} !== {1'b1, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL cg_done got rv=%b rd=%h mm=%b want 1 00 0", o_rsp_valid, o_rsp_data, o_rsp_mismatch);
      end
      i_bp_valid = 1'b0; i_rsp_ready = 1'b1;
      step();
      i_rsp_ready = 1'b0;
   endtask

   task automatic test_async_reset;
      int lat;
      logic [7:0] rd;
      logic mm, to;
      i_req_valid = 1'b1; i_req_wr = 1'b1; i_req_addr = 7'h21; i_req_data = 8'h5A; i_req_expect = 8'h00;
      i_bp_ready = 1'b1; i_bp_valid = 1'b0; i_rsp_ready = 1'b0;
      step();
      i_req_valid = 1'b0;
      step();
      checks++;
      if ({o_bp_valid, o_bp_data} !== {1'b1, 8'h5A}) begin
         errors++;
         $display("FAIL arst_in_data got bpv=%b bpd=%h want 1 5a", o_bp_valid, o_bp_data);
      end
      i_bp_ready = 1'b0;
      #2;
      i_rst_n = 1'b0;
      #1;
      checks++;
      if ({o_bp_valid, o_bp_data, o_req_ready, o_bp_ready} !== {1'b1 ^ 1'b1, 8'h00, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL arst_async got bpv=%b bpd=%h rq=%b bpr=%b want 0 00 1 0", o_bp_valid, o_bp_data, o_req_ready, o_bp_ready);
      end
      step();
      i_rst_n = 1'b1;
      step();
      sent.delete();
      run_txn(1'b0, 7'h07, 8'h00, 8'h99, 1'b1, 8'h99, lat, rd, mm, to);
      checks++;
      if (lat != 3 || rd !== 8'h99 || mm !== 1'b0 || to !== 1'b0) begin
         errors++;
         $display("FAIL arst_next_txn got lat=%0d rd=%h mm=%b to=%b want 3 99 0 0", lat, rd, mm, to);
      end
      checks++;
      if (sent.size() != 1 || sent[0] !== 8'h07) begin
         errors++;
         $display("FAIL arst_next_bytes got n=%0d want n=1 (07)", sent.size());
      end
   endtask

`ifdef BP_INITIATOR_TIMEOUT_EN
   task automatic test_timeout;
      int lat;
      logic [7:0] rd;
      logic mm, to;
      logic bad;
      run_txn(1'b0, 7'h0A, 8'h00, 8'h11, 1'b0, 8'h00, lat, rd, mm, to);
      checks++;
      if (lat != 6 || rd !== 8'h00 || mm !== 1'b0 || to !== 1'b1) begin
         errors++;
         $display("FAIL timeout_silent got lat=%0d rd=%h mm=%b to=%b want 6 00 0 1", lat, rd, mm, to);
      end
      bad = 1'b0;
      i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_addr = 7'h0B; i_req_expect = 8'h5A;
      i_bp_ready = 1'b1; i_bp_valid = 1'b0; i_rsp_ready = 1'b0;
      step();
      i_req_valid = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         step();
         if ({o_rsp_valid, o_bp_ready} !== 2'b01) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL timeout_wait got rv=%b bpr=%b want 0 1 for 3 cycles", o_rsp_valid, o_bp_ready);
      end
      i_bp_valid = 1'b1; i_bp_data = 8'h5A;
      step();
      checks++;
      if ({o_rsp_valid, o_rsp_data, o_rsp_mismatch, o_rsp_timeout} !== {1'b1, 8'h5A, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL timeout_race got rv=%b rd=%h mm=%b to=%b want 1 5a 0 0", o_rsp_valid, o_rsp_data, o_rsp_mismatch, o_rsp_timeout);
      end
      i_bp_valid = 1'b0; i_rsp_ready = 1'b1;
      step();
      i_rsp_ready = 1'b0;
   endtask
`else
   task automatic test_no_timeout;
      logic bad;
      bad = 1'b0;
      i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_addr = 7'h0A; i_req_expect = 8'h10;
      i_bp_ready = 1'b1; i_bp_valid = 1'b0; i_rsp_ready = 1'b0;
      step();
      i_req_valid = 1'b0;
      step();
      for (int i = 0; i < 20; i++) begin
         step();
         if ({o_rsp_valid, o_bp_ready, o_rsp_timeout} !== 3'b010) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL no_timeout_wait got rv=%b bpr=%b to=%b want 0 1 0 for 20 cycles", o_rsp_valid, o_bp_ready, o_rsp_timeout);
      end
      i_bp_valid = 1'b1; i_bp_data = 8'h10;
      step();
      checks++;
      if ({o_rsp_valid, o_rsp_data, o_rsp_mismatch, o_rsp_timeout} !== {1'b1, 8'h10, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL no_timeout_done got rv=%b rd=%h mm=%b to=%b want 1 10 0 0", o_rsp_valid, o_rsp_data, o_rsp_mismatch, o_rsp_timeout);
      end
      i_bp_valid = 1'b0; i_rsp_ready = 1'b1;
      step();
      i_rsp_ready = 1'b0;
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_read();
      test_write();
      test_stall();
      test_cg();
      test_async_reset();
`ifdef BP_INITIATOR_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bp_initiator.md
BP_INITIATOR -- requirements
Module: bp_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, range 1..255; max cycles waited in RESP for the response byte (used only with timeout compiled in).
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  asynchronous active-low reset.
REQ-004 i_cg  input  1  clock-gate enable; when 0, all state holds.
REQ-005 i_req_valid / o_req_ready  input/output  1/1  request handshake.
REQ-006 i_req_wr  input  1  1 = write transaction, 0 = read transaction.
REQ-007 i_req_addr  input  7  target register address.
REQ-008 i_req_data  input  8  write data, ignored for reads.
REQ-009 i_req_expect  input  8  value the response byte is expected to equal.
REQ-010 o_bp_data / o_bp_valid / i_bp_ready  output/output/input  8/1/1  outgoing BytePipe toward responder.
REQ-011 i_bp_data / i_bp_valid / o_bp_ready  input/input/output  8/1/1  incoming BytePipe from responder.
REQ-012 o_rsp_valid / i_rsp_ready  output/input  1/1  response handshake.
REQ-013 o_rsp_data  output  8  captured response byte (previous value for write, read value for read).
REQ-014 o_rsp_mismatch  output  1  o_rsp_data differs from the latched i_req_expect.
REQ-015 o_rsp_timeout  output  1  response abandoned by timeout.

Function
REQ-016 Handshakes: a transfer occurs on a cycle with valid && ready && i_cg; valid, once asserted, holds with stable payload until the transfer.
REQ-017 FSM states: IDLE, CMD, DATA, RESP, DONE; exactly one transaction outstanding.
REQ-018 IDLE: o_req_ready=1; on request transfer, latch wr, addr, data, expect; next state CMD.
REQ-019 CMD: o_bp_valid=1, o_bp_data={wr,addr}; on transfer go to DATA if wr, else RESP.
REQ-020 DATA: o_bp_valid=1, o_bp_data=latched data; on transfer go to RESP.
REQ-021 RESP: o_bp_ready=1; on i_bp_valid capture i_bp_data into o_rsp_data, compute mismatch, go to DONE.
REQ-022 DONE: o_rsp_valid=1; outputs stable; on response transfer go to IDLE.
REQ-023 o_req_ready=0 outside IDLE; o_bp_valid=0 outside CMD/DATA; o_bp_ready=0 outside RESP; o_rsp_valid=0 outside DONE.
REQ-024 Min latency: read request transfer to o_rsp_valid = 3 cycles with zero stalls; write = 4 cycles.
REQ-025 Bytes arriving on i_bp_valid outside RESP are not accepted (stall upstream) and never corrupt state.
REQ-026 DONE to IDLE transition and new request acceptance take separate cycles (no same-cycle reuse).

Reset
REQ-027 Assertion of i_rst_n=0 forces IDLE immediately, irrespective of i_cg or current state, including mid-transaction.
REQ-028 Reset values: o_req_ready=1 after release; o_bp_valid=0, o_bp_data=0, o_bp_ready=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_mismatch=0, o_rsp_timeout=0, timeout counter 0.

Configuration
REQ-029 Macro BP_INITIATOR_TIMEOUT_EN defined: 8b counter clears on entering RESP, increments each gated cycle in RESP; reaching TIMEOUT_CYCLES without a response byte moves to DONE with o_rsp_data=0, o_rsp_timeout=1, o_rsp_mismatch=0.
REQ-030 A response byte and timeout in the same cycle: response byte wins, o_rsp_timeout=0.
REQ-031 Macro undefined: no counter instantiated, RESP waits indefinitely, o_rsp_timeout tied 0.

Verification
REQ-032 Read addr 0x05, expect 0x00; responder replies 0x3C -> o_bp_data 0x05 once, o_rsp_data 0x3C, o_rsp_mismatch=1, 3-cycle latency with no stalls.
REQ-033 Write addr 0x12 data 0xA5 expect 0x00; reply 0x00 -> bytes 0x92 then 0xA5, o_rsp_data 0x00, mismatch=0, 4-cycle latency.
REQ-034 i_bp_ready low 5 cycles during CMD, i_rsp_ready low 3 cycles in DONE -> payloads held stable, no duplicate bytes, single response.
REQ-035 i_rst_n pulsed low while in DATA -> o_bp_valid drops asynchronously, FSM IDLE, next request runs cleanly.
REQ-036 BP_INITIATOR_TIMEOUT_EN, TIMEOUT_CYCLES=4, responder silent -> o_rsp_valid after 4 RESP cycles with o_rsp_timeout=1, o_rsp_data 0x00; reply arriving on the 4th cycle -> o_rsp_timeout=0.
